// File: rtl/uno_seq_if.sv
// Request/response handshake bundle between a unary-op issuer and uno_seq.
// The master issues requests and consumes responses; the slave is the sequencer.
interface uno_seq_if #(
    parameter int MUL_BW = 16,
    parameter int ITER_W = 4
) ();
    logic                     req_valid;
    logic                     req_ready;
    logic [1:0]               req_op;
    logic signed [MUL_BW-1:0] req_x;
    logic [ITER_W-1:0]        req_iter;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [1:0]               rsp_op;
    logic                     rsp_err;

    modport master (
        output req_valid, req_op, req_x, req_iter, rsp_ready,
        input  req_ready, rsp_valid, rsp_op, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_x, req_iter, rsp_ready,
        output req_ready, rsp_valid, rsp_op, rsp_err
    );
endinterface

// File: rtl/uno_seq.sv
// Unary-function sequencer: sets up the variable generator, walks the MAC
// through a Horner evaluation of N terms, then returns one response.
module uno_seq #(
    parameter int MUL_BW = 16,
    parameter int ITER_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    uno_seq_if.slave                 bus,
    input  logic                     flush,
    output logic [1:0]               gemm_uno_o,
    output logic signed [MUL_BW-1:0] x_o,
    output logic                     acc_clr_o,
    output logic                     acc_en_o,
    output logic [ITER_W-1:0]        coef_idx_o,
    output logic [CNT_W-1:0]         done_cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREP,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [1:0]        OP_GEMM = 2'b00;
    localparam logic [ITER_W-1:0] ITER_ONE = ITER_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    state_t                   r_state;
    logic [1:0]               r_op;
    logic [ITER_W-1:0]        r_last_idx;
    logic [1:0]               r_gemm;
    logic signed [MUL_BW-1:0] r_x;
    logic                     r_acc_clr;
    logic                     r_acc_en;
    logic [ITER_W-1:0]        r_coef_idx;
    logic                     r_rsp_valid;
    logic [1:0]               r_rsp_op;
    logic                     r_rsp_err;
    logic [CNT_W-1:0]         r_done_cnt;

    logic                     w_req_ready;

    assign w_req_ready = (r_state == S_IDLE) && !flush;

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values of its peers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_op        <= OP_GEMM;
            r_last_idx  <= '0;
            r_gemm      <= OP_GEMM;
            r_x         <= '0;
            r_acc_clr   <= 1'b0;
            r_acc_en    <= 1'b0;
            r_coef_idx  <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_op    <= OP_GEMM;
            r_rsp_err   <= 1'b0;
            r_done_cnt  <= '0;
        end else if (flush) begin
            // Abort wins over every transition and never touches the counter.
            r_state     <= S_IDLE;
            r_gemm      <= OP_GEMM;
            r_acc_clr   <= 1'b0;
            r_acc_en    <= 1'b0;
            r_rsp_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_op       <= bus.req_op;
                        r_last_idx <= (bus.req_iter == '0) ? '0 : bus.req_iter - ITER_ONE;
                        if (bus.req_op == OP_GEMM) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_op    <= OP_GEMM;
                            r_rsp_err   <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_gemm    <= bus.req_op;
                            r_x       <= bus.req_x;
                            r_acc_clr <= 1'b1;
                            r_state   <= S_PREP;
                        end
                    end
                end
                S_PREP: begin
                    r_acc_clr  <= 1'b0;
                    r_acc_en   <= 1'b1;
                    r_coef_idx <= r_last_idx;
                    r_state    <= S_RUN;
                end
                S_RUN: begin
                    if (r_coef_idx == '0) begin
                        r_acc_en    <= 1'b0;
                        r_gemm      <= OP_GEMM;
                        r_rsp_valid <= 1'b1;
                        r_rsp_op    <= r_op;
                        r_rsp_err   <= 1'b0;
                        r_state     <= S_DONE;
                    end else begin
                        r_coef_idx <= r_coef_idx - ITER_ONE;
                    end
                end
                S_DONE: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                        if (!r_rsp_err && (r_done_cnt != '1)) begin
                            r_done_cnt <= r_done_cnt + CNT_ONE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_op    = r_rsp_op;
    assign bus.rsp_err   = r_rsp_err;
    assign gemm_uno_o    = r_gemm;
    assign x_o           = r_x;
    assign acc_clr_o     = r_acc_clr;
    assign acc_en_o      = r_acc_en;
    assign coef_idx_o    = r_coef_idx;
    assign done_cnt_o    = r_done_cnt;

endmodule

// File: tb/tb_uno_seq.sv
// Directed bench for uno_seq; a 2-bit completion counter makes saturation reachable.
module tb_uno_seq;
    localparam int MUL_BW = 16;
    localparam int ITER_W = 4;
    localparam int CNT_W  = 2;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     flush;
    logic [1:0]               gemm_uno_o;
    logic signed [MUL_BW-1:0] x_o;
    logic                     acc_clr_o;
    logic                     acc_en_o;
    logic [ITER_W-1:0]        coef_idx_o;
    logic [CNT_W-1:0]         done_cnt_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    uno_seq_if #(.MUL_BW(MUL_BW), .ITER_W(ITER_W)) bus ();

    uno_seq #(.MUL_BW(MUL_BW), .ITER_W(ITER_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus.slave),
        .flush      (flush),
        .gemm_uno_o (gemm_uno_o),
        .x_o        (x_o),
        .acc_clr_o  (acc_clr_o),
        .acc_en_o   (acc_en_o),
        .coef_idx_o (coef_idx_o),
        .done_cnt_o (done_cnt_o)
    );

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one cycle; returns in the cycle after the handshake.
    task automatic issue(input logic [1:0] op, input logic [MUL_BW-1:0] x, input logic [ITER_W-1:0] n);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_x     = x;
        bus.req_iter  = n;
        step();
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (!bus.req_ready && n < 50) begin
            step();
            n++;
        end
        n_checks++;
        if (bus.req_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL %s_timeout: req_ready=%b want 1 within 50 cycles", tag, bus.req_ready);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        n_checks++;
        if ({gemm_uno_o, x_o, acc_clr_o, acc_en_o, coef_idx_o, bus.rsp_valid, bus.rsp_op, bus.rsp_err, done_cnt_o, bus.req_ready}
            !== {2'b00, 16'h0000, 1'b0, 1'b0, 4'h0, 1'b0, 2'b00, 1'b0, 2'd0, 1'b1}) begin
            n_errors++;
            $display("FAIL %s: gemm=%b x=%h clr=%b en=%b idx=%0d rv=%b rop=%b rerr=%b cnt=%0d rdy=%b want all zero and rdy=1",
                     tag, gemm_uno_o, x_o, acc_clr_o, acc_en_o, coef_idx_o, bus.rsp_valid, bus.rsp_op,
                     bus.rsp_err, done_cnt_o, bus.req_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        flush = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_op    = 2'b00;
        bus.req_x     = '0;
        bus.req_iter  = '0;
        bus.rsp_ready = 1'b1;
        #2;
        check_reset_outputs("reset_state");
        step();
        step();
        rst_n = 1'b1;
        step();
        check_reset_outputs("after_reset_release");
    endtask

    task automatic test_exp();
        issue(2'b10, 16'h0C00, 4'd4);
        n_checks++;
        if ({gemm_uno_o, acc_clr_o, acc_en_o, x_o, bus.req_ready} !== {2'b10, 1'b1, 1'b0, 16'h0C00, 1'b0}) begin
            n_errors++;
            $display("FAIL exp_prep: gemm=%b clr=%b en=%b x=%h rdy=%b want 10 1 0 0c00 0",
                     gemm_uno_o, acc_clr_o, acc_en_o, x_o, bus.req_ready);
        end
        for (int i = 3; i >= 0; i--) begin
            step();
            n_checks++;
            if ({acc_en_o, acc_clr_o, gemm_uno_o, coef_idx_o, bus.rsp_valid} !== {1'b1, 1'b0, 2'b10, 4'(i), 1'b0}) begin
                n_errors++;
                $display("FAIL exp_run_%0d: en=%b clr=%b gemm=%b idx=%0d rv=%b want 1 0 10 %0d 0",
                         i, acc_en_o, acc_clr_o, gemm_uno_o, coef_idx_o, bus.rsp_valid, i);
            end
        end
        step();
        n_checks++;
        if ({bus.rsp_valid, bus.rsp_op, bus.rsp_err, acc_en_o, gemm_uno_o} !== {1'b1, 2'b10, 1'b0, 1'b0, 2'b00}) begin
            n_errors++;
            $display("FAIL exp_done: rv=%b rop=%b rerr=%b en=%b gemm=%b want 1 10 0 0 00",
                     bus.rsp_valid, bus.rsp_op, bus.rsp_err, acc_en_o, gemm_uno_o);
        end
        step();
        n_checks++;
        if ({done_cnt_o, bus.rsp_valid, bus.req_ready} !== {2'd1, 1'b0, 1'b1}) begin
            n_errors++;
            $display("FAIL exp_count: cnt=%0d rv=%b rdy=%b want 1 0 1", done_cnt_o, bus.rsp_valid, bus.req_ready);
        end
    endtask

    task automatic test_log_n0();
        issue(2'b11, 16'h0100, 4'd0);
        n_checks++;
        if ({gemm_uno_o, acc_clr_o} !== {2'b11, 1'b1}) begin
            n_errors++;
            $display("FAIL log_prep: gemm=%b clr=%b want 11 1", gemm_uno_o, acc_clr_o);
        end
        step();
        n_checks++;
        if ({acc_en_o, coef_idx_o, bus.rsp_valid} !== {1'b1, 4'd0, 1'b0}) begin
            n_errors++;
            $display("FAIL log_run: en=%b idx=%0d rv=%b want 1 0 0", acc_en_o, coef_idx_o, bus.rsp_valid);
        end
        step();
        n_checks++;
        if ({bus.rsp_valid, bus.rsp_op, acc_en_o} !== {1'b1, 2'b11, 1'b0}) begin
            n_errors++;
            $display("FAIL log_done: rv=%b rop=%b en=%b want 1 11 0", bus.rsp_valid, bus.rsp_op, acc_en_o);
        end
        step();
        n_checks++;
        if (done_cnt_o !== 2'd2) begin
            n_errors++;
            $display("FAIL log_count: cnt=%0d want 2", done_cnt_o);
        end
    endtask

    task automatic test_illegal();
        issue(2'b00, 16'h1234, 4'd5);
        n_checks++;
        if ({bus.rsp_valid, bus.rsp_err, bus.rsp_op, acc_en_o, acc_clr_o, gemm_uno_o} !== {1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00}) begin
            n_errors++;
            $display("FAIL illegal_done: rv=%b rerr=%b rop=%b en=%b clr=%b gemm=%b want 1 1 00 0 0 00",
                     bus.rsp_valid, bus.rsp_err, bus.rsp_op, acc_en_o, acc_clr_o, gemm_uno_o);
        end
        step();
        n_checks++;
        if ({done_cnt_o, bus.rsp_valid, bus.req_ready, acc_en_o} !== {2'd2, 1'b0, 1'b1, 1'b0}) begin
            n_errors++;
            $display("FAIL illegal_count: cnt=%0d rv=%b rdy=%b en=%b want 2 0 1 0",
                     done_cnt_o, bus.rsp_valid, bus.req_ready, acc_en_o);
        end
    endtask

    task automatic test_flush();
        issue(2'b10, 16'h0200, 4'd8);
        step();
        step();
        n_checks++;
        if ({acc_en_o, coef_idx_o} !== {1'b1, 4'd6}) begin
            n_errors++;
            $display("FAIL flush_pre: en=%b idx=%0d want 1 6", acc_en_o, coef_idx_o);
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        #1;
        n_checks++;
        if ({acc_en_o, acc_clr_o, gemm_uno_o, bus.rsp_valid, bus.req_ready, done_cnt_o} !== {1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 2'd2}) begin
            n_errors++;
            $display("FAIL flush_run: en=%b clr=%b gemm=%b rv=%b rdy=%b cnt=%0d want 0 0 00 0 1 2",
                     acc_en_o, acc_clr_o, gemm_uno_o, bus.rsp_valid, bus.req_ready, done_cnt_o);
        end
        for (int i = 0; i < 8; i++) begin
            step();
            n_checks++;
            if ({bus.rsp_valid, acc_en_o} !== 2'b00) begin
                n_errors++;
                $display("FAIL flush_quiet_%0d: rv=%b en=%b want 0 0", i, bus.rsp_valid, acc_en_o);
            end
        end
        bus.req_valid = 1'b1;
        bus.req_op    = 2'b01;
        bus.req_iter  = 4'd2;
        flush = 1'b1;
        #1;
        n_checks++;
        if (bus.req_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL flush_idle_ready: rdy=%b want 0", bus.req_ready);
        end
        step();
        bus.req_valid = 1'b0;
        flush = 1'b0;
        #1;
        n_checks++;
        if ({gemm_uno_o, acc_clr_o, bus.rsp_valid, bus.req_ready, done_cnt_o} !== {2'b00, 1'b0, 1'b0, 1'b1, 2'd2}) begin
            n_errors++;
            $display("FAIL flush_idle_reject: gemm=%b clr=%b rv=%b rdy=%b cnt=%0d want 00 0 0 1 2",
                     gemm_uno_o, acc_clr_o, bus.rsp_valid, bus.req_ready, done_cnt_o);
        end
    endtask

    task automatic test_back_to_back();
        bus.rsp_ready = 1'b0;
        issue(2'b01, 16'hFF00, 4'd3);
        step();
        step();
        step();
        step();
        bus.req_valid = 1'b1;
        bus.req_op    = 2'b10;
        bus.req_x     = 16'h0040;
        bus.req_iter  = 4'd1;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if ({bus.rsp_valid, bus.rsp_op, bus.rsp_err, bus.req_ready, gemm_uno_o} !== {1'b1, 2'b01, 1'b0, 1'b0, 2'b00}) begin
                n_errors++;
                $display("FAIL bp_hold_%0d: rv=%b rop=%b rerr=%b rdy=%b gemm=%b want 1 01 0 0 00",
                         i, bus.rsp_valid, bus.rsp_op, bus.rsp_err, bus.req_ready, gemm_uno_o);
            end
            step();
        end
        bus.rsp_ready = 1'b1;
        #1;
        n_checks++;
        if ({bus.rsp_valid, bus.req_ready} !== 2'b10) begin
            n_errors++;
            $display("FAIL bp_handshake: rv=%b rdy=%b want 1 0", bus.rsp_valid, bus.req_ready);
        end
        step();
        n_checks++;
        if ({bus.rsp_valid, bus.req_ready, done_cnt_o} !== {1'b0, 1'b1, 2'd3}) begin
            n_errors++;
            $display("FAIL bp_release: rv=%b rdy=%b cnt=%0d want 0 1 3", bus.rsp_valid, bus.req_ready, done_cnt_o);
        end
        step();
        bus.req_valid = 1'b0;
        n_checks++;
        if ({gemm_uno_o, acc_clr_o, x_o} !== {2'b10, 1'b1, 16'h0040}) begin
            n_errors++;
            $display("FAIL bp_next_accept: gemm=%b clr=%b x=%h want 10 1 0040", gemm_uno_o, acc_clr_o, x_o);
        end
        wait_idle("bp_next");
        n_checks++;
        if (done_cnt_o !== 2'd3) begin
            n_errors++;
            $display("FAIL bp_next_count: cnt=%0d want 3", done_cnt_o);
        end
    endtask

    task automatic test_reset_mid_run();
        issue(2'b10, 16'h0C00, 4'd8);
        step();
        step();
        n_checks++;
        if ({acc_en_o, gemm_uno_o} !== {1'b1, 2'b10}) begin
            n_errors++;
            $display("FAIL rst_mid_pre: en=%b gemm=%b want 1 10", acc_en_o, gemm_uno_o);
        end
        rst_n = 1'b0;
        #2;
        check_reset_outputs("rst_mid_async");
        step();
        rst_n = 1'b1;
        step();
        check_reset_outputs("rst_mid_release");
    endtask

    task automatic test_saturation();
        logic [CNT_W-1:0] exp_cnt;
        bus.rsp_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            issue(2'b01, 16'h0010, 4'd1);
            wait_idle("sat");
            exp_cnt = (k >= 3) ? 2'd3 : 2'(k);
            n_checks++;
            if (done_cnt_o !== exp_cnt) begin
                n_errors++;
                $display("FAIL sat_%0d: cnt=%0d want %0d", k, done_cnt_o, exp_cnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_exp();
        test_log_n0();
        test_illegal();
        test_flush();
        test_back_to_back();
        test_reset_mid_run();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/uno_seq.md
# uno_seq

Sequencer for the unary-function path of a RAVEN PE. It accepts one div/exp/log request at a time and drives the 2-bit mode code and operand into the variable generator. It then steps the downstream multiply-accumulate through a Horner evaluation of N coefficient terms and returns a completion response. One request is in flight at a time, and the block keeps a saturating count of completed operations.

## Interface
Parameters:
- MUL_BW, 16, operand width (matches variable generator)
- ITER_W, 4, width of term count and coefficient index
- CNT_W, 16, width of completed-operation counter

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept a request
- req_op  in  2  01 div, 10 exp, 11 log, 00 illegal (gemm)
- req_x  in  MUL_BW  signed operand
- req_iter  in  ITER_W  number of polynomial terms N; 0 is treated as 1
- flush  in  1  synchronous abort
- gemm_uno_o  out  2  mode code to variable generator
- x_o  out  MUL_BW  operand to variable generator
- acc_clr_o  out  1  clear downstream accumulator
- acc_en_o  out  1  downstream accumulate enable
- coef_idx_o  out  ITER_W  coefficient ROM index
- rsp_valid  out  1  result complete
- rsp_ready  in  1  consumer takes the response
- rsp_op  out  2  op code of the completed request
- rsp_err  out  1  request had illegal op 00
- done_cnt_o  out  CNT_W  completed legal operations, saturating

## Operation
- States: IDLE, PREP, RUN, DONE. State register and all registered outputs reset asynchronously.
- Reset values:
  - state IDLE; gemm_uno_o=00, x_o=0, acc_clr_o=0, acc_en_o=0, coef_idx_o=0, rsp_valid=0, rsp_op=00, rsp_err=0, done_cnt_o=0.
  - req_ready=1 (it is combinational: IDLE && !flush).
- IDLE:
  - On req_valid && req_ready, latch op, x and Neff = (req_iter==0 ? 1 : req_iter).
  - op 00 → DONE with rsp_err=1, rsp_op=00; no PREP/RUN.
  - Otherwise → PREP.
- PREP (1 cycle):
  - gemm_uno_o=op, x_o=x, acc_clr_o=1. Covers the variable generator's 1-cycle register latency.
  - → RUN with the index counter loaded to Neff-1.
- RUN (Neff cycles):
  - acc_en_o=1, coef_idx_o = counter, counting down to 0. gemm_uno_o and x_o held.
  - Leaving at counter==0 → DONE.
- DONE:
  - rsp_valid=1, rsp_op=op, rsp_err as latched. gemm_uno_o returns to 00, acc_en_o=0.
  - Held until rsp_ready → IDLE.
  - done_cnt_o increments on that handshake only if rsp_err=0. It saturates at 2^CNT_W-1.
- flush:
  - In any state, the next state is IDLE. acc_en_o, acc_clr_o and rsp_valid drop next cycle, and gemm_uno_o goes to 00.
  - No response is produced and the counter is not changed.
  - flush with req_valid in IDLE: the request is not accepted.
- gemm_uno_o is 00 whenever the state is not PREP or RUN, so the variable generator outputs 0.

## Timing
- Request handshake in cycle T: PREP in T+1; RUN in T+2 .. T+Neff+1; rsp_valid first high in T+Neff+2.
- coef_idx_o = Neff-1 in T+2, reaching 0 in T+Neff+1.
- Illegal op accepted in T: rsp_valid in T+1.
- Response handshake in cycle D: IDLE and req_ready=1 in D+1. A new request can be accepted in D+1. Minimum issue interval is Neff+3 cycles.
- req_ready is low in PREP, RUN and DONE.
- rsp_valid, rsp_op and rsp_err stay stable while rsp_valid && !rsp_ready.
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronously).

## Test plan
- Exp, x=0x0C00, N=4, rsp_ready tied 1. Required response:
  - gemm_uno_o=10 and acc_clr_o=1 in T+1.
  - acc_en_o high T+2..T+5 with coef_idx_o 3,2,1,0.
  - rsp_valid in T+6 with rsp_op=10; done_cnt_o=1 in T+7.
- Log, N=0: a single RUN cycle with coef_idx_o=0; rsp_valid in T+3.
- Op 00: rsp_valid and rsp_err=1 in T+1, no acc_en_o pulse, done_cnt_o unchanged.
- Div, N=3, rsp_ready held low 5 cycles after rsp_valid rises:
  - rsp_valid stable throughout; req_valid asserted meanwhile is not accepted.
  - Accepted in the cycle after the rsp handshake.
- flush in the second RUN cycle of an N=8 exp:
  - Next cycle IDLE, acc_en_o=0, gemm_uno_o=00, no rsp_valid, done_cnt_o unchanged.
  - flush with req_valid in IDLE: the request is not accepted.
- Reset asserted mid-RUN: all outputs return to reset values with no clock edge.
- Counter saturation with CNT_W=2: four legal completions give done_cnt_o=3 and it holds.
